sr_latch_bank: RTL and testbench

//   Parametrised, clocked successor to the gate-level SR latch: N independent set/reset

---
 rtl/sr_bank_pkg.sv | 34 +++
 rtl/sr_latch_bank_cell.sv | 93 +++++++++
 rtl/sr_latch_bank.sv | 70 +++++++
 tb/tb_sr_latch_bank.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_bank_pkg.sv
// Shared constants and the per-channel next-state rule for the SR flag bank.
package sr_bank_pkg;

    // Outcome when set and reset are both active in the same cycle
    localparam int PRI_SET    = 0;
    localparam int PRI_RESET  = 1;
    localparam int PRI_TOGGLE = 2;
    localparam int PRI_HOLD   = 3;

    // Event detection: active-low level, or falling edge only
    localparam int MODE_LEVEL = 0;
    localparam int MODE_EDGE  = 1;

    // Next flag value from this cycle's set/reset events and the current flag
    function automatic logic next_q(input logic s_ev, input logic r_ev,
                                    input logic q, input int pri);
        logic n;
        n = q;
        if (s_ev && !r_ev) begin
            n = 1'b1;
        end else if (r_ev && !s_ev) begin
            n = 1'b0;
        end else if (s_ev && r_ev) begin
            case (pri)
                PRI_SET:    n = 1'b1;
                PRI_RESET:  n = 1'b0;
                PRI_TOGGLE: n = ~q;
                default:    n = q;
            endcase
        end
        return n;
    endfunction

endpackage

// File: rtl/sr_latch_bank_cell.sv
// One flag channel: input synchroniser, optional falling-edge detector,
// next-state selection, and the registered flag with its change pulse.
module sr_cell
    import sr_bank_pkg::*;
#(
    parameter int   PRIORITY    = PRI_SET,
    parameter int   EDGE_MODE   = MODE_LEVEL,
    parameter int   SYNC_STAGES = 2,
    parameter logic RESET_Q     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic sbar,
    input  logic rbar,
    output logic q,
    output logic change,
    output logic conflict
);

    logic w_s_sync;
    logic w_r_sync;
    logic w_s_ev;
    logic w_r_ev;
    logic w_next;
    logic r_q;
    logic r_change;

    if (SYNC_STAGES == 0) begin : g_nosync
        assign w_s_sync = sbar;
        assign w_r_sync = rbar;
    end else begin : g_sync
        logic [SYNC_STAGES-1:0] r_s_chain;
        logic [SYNC_STAGES-1:0] r_r_chain;

        // Shift the raw inputs through the synchroniser; reset loads the inactive level
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s_chain <= '1;
                r_r_chain <= '1;
            end else begin
                r_s_chain[0] <= sbar;
                r_r_chain[0] <= rbar;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    r_s_chain[i] <= r_s_chain[i-1];
                    r_r_chain[i] <= r_r_chain[i-1];
                end
            end
        end

        assign w_s_sync = r_s_chain[SYNC_STAGES-1];
        assign w_r_sync = r_r_chain[SYNC_STAGES-1];
    end

    if (EDGE_MODE == MODE_EDGE) begin : g_edge
        logic r_s_prev;
        logic r_r_prev;

        // Remember last synced level; reset to inactive so no edge spans reset release
        always_ff @(posedge clk) begin
            if (rst) begin
                r_s_prev <= 1'b1;
                r_r_prev <= 1'b1;
            end else begin
                r_s_prev <= w_s_sync;
                r_r_prev <= w_r_sync;
            end
        end

        assign w_s_ev = r_s_prev & ~w_s_sync;
        assign w_r_ev = r_r_prev & ~w_r_sync;
    end else begin : g_level
        assign w_s_ev = ~w_s_sync;
        assign w_r_ev = ~w_r_sync;
    end

    assign w_next = next_q(w_s_ev, w_r_ev, r_q, PRIORITY);

    // Update the flag and flag any cycle where it takes a new value
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= RESET_Q;
            r_change <= 1'b0;
        end else begin
            r_q      <= w_next;
            r_change <= w_next ^ r_q;
        end
    end

    assign q        = r_q;
    assign change   = r_change;
    assign conflict = w_s_ev & w_r_ev;

endmodule

// File: rtl/sr_latch_bank.sv
// Bank of N clocked set/reset flags with active-low inputs, a shared
// saturating conflict counter and an any-flag-set summary.
module sr_latch_bank
    import sr_bank_pkg::*;
#(
    parameter int             N           = 8,
    parameter int             PRIORITY    = PRI_SET,
    parameter int             EDGE_MODE   = MODE_LEVEL,
    parameter int             SYNC_STAGES = 2,
    parameter int             CNT_W       = 8,
    parameter logic [N-1:0]   RESET_Q     = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     sbar,
    input  logic [N-1:0]     rbar,
    input  logic             conflict_clr,
    output logic [N-1:0]     q,
    output logic [N-1:0]     qbar,
    output logic [N-1:0]     change,
    output logic             any_set,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [N-1:0]     w_q;
    logic [N-1:0]     w_change;
    logic [N-1:0]     w_conflict;
    logic             w_any_conflict;
    logic [CNT_W-1:0] r_cnt;

    for (genvar g = 0; g < N; g++) begin : g_cell
        sr_cell #(
            .PRIORITY    (PRIORITY),
            .EDGE_MODE   (EDGE_MODE),
            .SYNC_STAGES (SYNC_STAGES),
            .RESET_Q     (RESET_Q[g])
        ) u_cell (
            .clk      (clk),
            .rst      (rst),
            .sbar     (sbar[g]),
            .rbar     (rbar[g]),
            .q        (w_q[g]),
            .change   (w_change[g]),
            .conflict (w_conflict[g])
        );
    end

    // A cycle counts once however many channels conflict in it
    assign w_any_conflict = |w_conflict;

    // Saturating conflict counter; clear takes precedence over an increment
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (conflict_clr) begin
            r_cnt <= '0;
        end else if (w_any_conflict && (r_cnt != CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign q            = w_q;
    assign qbar         = ~w_q;
    assign change       = w_change;
    assign any_set      = |w_q;
    assign conflict_cnt = r_cnt;

endmodule

// File: tb/tb_sr_latch_bank.sv
// Scoreboard bench for sr_latch_bank: four priority variants share one
// stimulus bus, plus an edge-mode instance and a 2-bit-counter instance.
module tb_sr_latch_bank;

    typedef struct {
        int         cyc;
        int         inst;
        logic [3:0] q;
        logic [3:0] chg;
        int         cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [3:0] sbar = 4'hF, rbar = 4'hF;
    logic [3:0] e_sbar = 4'hF, e_rbar = 4'hF;
    logic [3:0] c_sbar = 4'hF, c_rbar = 4'hF;
    logic c_clr = 1'b0;
    logic clr0 = 1'b0;

    logic [5:0][3:0] q_w, qb_w, chg_w;
    logic [5:0]      any_w;
    logic [5:0][7:0] cnt_w;
    logic [1:0]      cnt5;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sbq[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 4; g++) begin : g_pri
        sr_latch_bank #(.N(4), .PRIORITY(g), .EDGE_MODE(0), .SYNC_STAGES(2),
                        .CNT_W(8), .RESET_Q(4'b0000)) u_dut (
            .clk(clk), .rst(rst), .sbar(sbar), .rbar(rbar), .conflict_clr(clr0),
            .q(q_w[g]), .qbar(qb_w[g]), .change(chg_w[g]), .any_set(any_w[g]),
            .conflict_cnt(cnt_w[g]));
    end

    sr_latch_bank #(.N(4), .PRIORITY(0), .EDGE_MODE(1), .SYNC_STAGES(2),
                    .CNT_W(8), .RESET_Q(4'b0000)) u_edge (
        .clk(clk), .rst(rst), .sbar(e_sbar), .rbar(e_rbar), .conflict_clr(clr0),
        .q(q_w[4]), .qbar(qb_w[4]), .change(chg_w[4]), .any_set(any_w[4]),
        .conflict_cnt(cnt_w[4]));

    sr_latch_bank #(.N(4), .PRIORITY(0), .EDGE_MODE(0), .SYNC_STAGES(2),
                    .CNT_W(2), .RESET_Q(4'b0000)) u_cnt (
        .clk(clk), .rst(rst), .sbar(c_sbar), .rbar(c_rbar), .conflict_clr(c_clr),
        .q(q_w[5]), .qbar(qb_w[5]), .change(chg_w[5]), .any_set(any_w[5]),
        .conflict_cnt(cnt5));

    assign cnt_w[5] = {6'b0, cnt5};

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_entry(input exp_t e);
        chk($sformatf("q inst%0d cyc%0d", e.inst, e.cyc), {4'b0, q_w[e.inst]}, {4'b0, e.q});
        chk($sformatf("qbar inst%0d cyc%0d", e.inst, e.cyc), {4'b0, qb_w[e.inst]}, {4'b0, ~e.q});
        chk($sformatf("change inst%0d cyc%0d", e.inst, e.cyc), {4'b0, chg_w[e.inst]}, {4'b0, e.chg});
        chk($sformatf("any_set inst%0d cyc%0d", e.inst, e.cyc), {7'b0, any_w[e.inst]}, {7'b0, |e.q});
        chk($sformatf("cnt inst%0d cyc%0d", e.inst, e.cyc), cnt_w[e.inst], 8'(e.cnt));
    endtask

    // Monitor: each falling edge, compare every expectation due this cycle
    always @(negedge clk) begin
        exp_t keep[$];
        keep = {};
        foreach (sbq[i]) begin
            if (sbq[i].cyc == cyc) begin
                check_entry(sbq[i]);
            end else if (sbq[i].cyc < cyc) begin
                n_checks++;
                n_fail++;
                $display("FAIL missed inst%0d cyc%0d", sbq[i].inst, sbq[i].cyc);
            end else begin
                keep.push_back(sbq[i]);
            end
        end
        sbq = keep;
    end

    task automatic expect_at(input int c, input int inst, input logic [3:0] q,
                             input logic [3:0] chg, input int cnt);
        exp_t e;
        e.cyc = c; e.inst = inst; e.q = q; e.chg = chg; e.cnt = cnt;
        sbq.push_back(e);
    endtask

    task automatic expect_all(input int c, input logic [3:0] q,
                              input logic [3:0] chg, input int cnt);
        for (int i = 0; i < 4; i++) expect_at(c, i, q, chg, cnt);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int e;
        // reset state on every instance
        for (int i = 0; i < 6; i++) expect_at(2, i, 4'h0, 4'h0, 0);
        tick(2);
        rst = 1'b0;

        // single set: three edges of latency, one change pulse
        c = cyc;
        sbar = 4'b1110;
        expect_all(c + 2, 4'h0, 4'h0, 0);
        expect_all(c + 3, 4'h1, 4'h1, 0);
        expect_all(c + 4, 4'h1, 4'h0, 0);
        tick(1);
        sbar = 4'hF;
        tick(5);

        // clear channel 0
        c = cyc;
        rbar = 4'b1110;
        expect_all(c + 3, 4'h0, 4'h1, 0);
        expect_all(c + 4, 4'h0, 4'h0, 0);
        tick(1);
        rbar = 4'hF;
        tick(5);

        // one-cycle conflict on channel 0 under each priority
        c = cyc;
        sbar = 4'b1110;
        rbar = 4'b1110;
        expect_at(c + 3, 0, 4'h1, 4'h1, 1);
        expect_at(c + 3, 1, 4'h0, 4'h0, 1);
        expect_at(c + 3, 2, 4'h1, 4'h1, 1);
        expect_at(c + 3, 3, 4'h0, 4'h0, 1);
        expect_at(c + 4, 0, 4'h1, 4'h0, 1);
        expect_at(c + 4, 1, 4'h0, 4'h0, 1);
        expect_at(c + 4, 2, 4'h1, 4'h0, 1);
        expect_at(c + 4, 3, 4'h0, 4'h0, 1);
        tick(1);
        sbar = 4'hF;
        rbar = 4'hF;
        tick(5);

        // restore channel 0 to zero
        c = cyc;
        rbar = 4'b1110;
        expect_at(c + 3, 0, 4'h0, 4'h1, 1);
        expect_at(c + 3, 1, 4'h0, 4'h0, 1);
        expect_at(c + 3, 2, 4'h0, 4'h1, 1);
        expect_at(c + 3, 3, 4'h0, 4'h0, 1);
        tick(1);
        rbar = 4'hF;
        tick(5);

        // level mode, set held low for 8 cycles
        c = cyc;
        sbar = 4'b1101;
        expect_all(c + 3, 4'h2, 4'h2, 1);
        for (int k = 4; k <= 12; k++) expect_all(c + k, 4'h2, 4'h0, 1);
        tick(8);
        sbar = 4'hF;
        tick(6);

        // reset while channel 0 pulses; nothing survives release
        c = cyc;
        sbar = 4'b0101;
        expect_all(c + 3, 4'hA, 4'h8, 1);
        expect_all(c + 4, 4'hA, 4'h0, 1);
        for (int k = 5; k <= 12; k++) expect_all(c + k, 4'h0, 4'h0, 0);
        tick(4);
        rst = 1'b1;
        sbar = 4'hF;
        tick(1);
        sbar = 4'b1110;
        tick(1);
        sbar = 4'hF;
        tick(1);
        rst = 1'b0;
        tick(7);

        // edge mode: held set gives one event, reset pulse during hold clears
        c = cyc;
        e_sbar = 4'b1011;
        expect_at(c + 3, 4, 4'h4, 4'h4, 0);
        for (int k = 4; k <= 8; k++) expect_at(c + k, 4, 4'h4, 4'h0, 0);
        expect_at(c + 9, 4, 4'h0, 4'h4, 0);
        for (int k = 10; k <= 14; k++) expect_at(c + k, 4, 4'h0, 4'h0, 0);
        tick(6);
        e_rbar = 4'b1011;
        tick(1);
        e_rbar = 4'hF;
        tick(3);
        e_sbar = 4'hF;
        tick(6);

        // 2-bit counter saturates, then clear beats a concurrent conflict
        c = cyc;
        c_sbar = 4'b1110;
        c_rbar = 4'b1110;
        expect_at(c + 3, 5, 4'h1, 4'h1, 1);
        expect_at(c + 4, 5, 4'h1, 4'h0, 2);
        expect_at(c + 5, 5, 4'h1, 4'h0, 3);
        expect_at(c + 6, 5, 4'h1, 4'h0, 3);
        expect_at(c + 7, 5, 4'h1, 4'h0, 3);
        expect_at(c + 8, 5, 4'h1, 4'h0, 3);
        e = c + 9;
        expect_at(e + 2, 5, 4'h1, 4'h0, 3);
        expect_at(e + 3, 5, 4'h1, 4'h0, 0);
        expect_at(e + 4, 5, 4'h1, 4'h0, 0);
        tick(5);
        c_sbar = 4'hF;
        c_rbar = 4'hF;
        tick(4);
        c_sbar = 4'b1110;
        c_rbar = 4'b1110;
        tick(1);
        c_sbar = 4'hF;
        c_rbar = 4'hF;
        tick(1);
        c_clr = 1'b1;
        tick(1);
        c_clr = 1'b0;
        tick(4);

        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard drain: got %0d pending expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
